// File: rtl/conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : conv_arbiter
//  Description : Shares one soc/eoc converter between two 4-phase requesters.
//                Round-robin on ties, one conversion in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_arbiter (
    input  logic       clock,
    input  logic       reset_,
    input  logic       req0,
    input  logic       req1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] d0,
    output logic [7:0] d1,
    output logic       soc,
    input  logic       eoc,
    input  logic [7:0] x,
    output logic [7:0] cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SOC_UP   = 2'd1,
        WAIT_EOC = 2'd2,
        ACK      = 2'd3
    } star_t;

    star_t       star;
    star_t       star_nx;
    logic        g;
    logic        g_nx;
    logic        l;
    logic        l_nx;
    logic        soc_nx;
    logic        ack0_nx;
    logic        ack1_nx;
    logic [7:0]  d0_nx;
    logic [7:0]  d1_nx;
    logic [7:0]  cnt_nx;
    logic        req_g;

    // Request line of whichever requester currently holds the grant.
    assign req_g = g ? req1 : req0;

    // State and output registers; reset lets requester 0 win the first tie (l=1).
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            star <= IDLE;
            g    <= 1'b0;
            l    <= 1'b1;
            soc  <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            d0   <= 8'd0;
            d1   <= 8'd0;
            cnt  <= 8'd0;
        end else begin
            star <= star_nx;
            g    <= g_nx;
            l    <= l_nx;
            soc  <= soc_nx;
            ack0 <= ack0_nx;
            ack1 <= ack1_nx;
            d0   <= d0_nx;
            d1   <= d1_nx;
            cnt  <= cnt_nx;
        end
    end

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        star_nx = star;
        g_nx    = g;
        l_nx    = l;
        soc_nx  = soc;
        ack0_nx = ack0;
        ack1_nx = ack1;
        d0_nx   = d0;
        d1_nx   = d1;
        cnt_nx  = cnt;
        case (star)
            IDLE: begin
                soc_nx = 1'b0;
                if (req0 || req1) begin
                    // A lone request wins outright; a tie goes to the one not served last.
                    g_nx    = (req0 && req1) ? ~l : req1;
                    soc_nx  = 1'b1;
                    star_nx = SOC_UP;
                end
            end
            SOC_UP: begin
                // eoc still high means the converter has not started yet: keep soc up.
                if (!eoc) begin
                    soc_nx  = 1'b0;
                    star_nx = WAIT_EOC;
                end
            end
            WAIT_EOC: begin
                if (eoc) begin
                    if (g) begin
                        d1_nx   = x;
                        ack1_nx = 1'b1;
                    end else begin
                        d0_nx   = x;
                        ack0_nx = 1'b1;
                    end
                    l_nx    = g;
                    cnt_nx  = cnt + 8'd1;
                    star_nx = ACK;
                end
            end
            ACK: begin
                // A requester that withdrew mid-conversion sees ack for a single cycle.
                if (!req_g) begin
                    ack0_nx = 1'b0;
                    ack1_nx = 1'b0;
                    star_nx = IDLE;
                end
            end
            default: begin
                star_nx = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_arbiter
//  Description : Randomized requesters and converter around conv_arbiter,
//                checked cycle by cycle against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_arbiter;

    logic       clock;
    logic       reset_;
    logic       req0;
    logic       req1;
    logic       ack0;
    logic       ack1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       soc;
    logic       eoc;
    logic [7:0] x;
    logic [7:0] cnt;

    conv_arbiter dut (
        .clock  (clock),
        .reset_ (reset_),
        .req0   (req0),
        .req1   (req1),
        .ack0   (ack0),
        .ack1   (ack1),
        .d0     (d0),
        .d1     (d1),
        .soc    (soc),
        .eoc    (eoc),
        .x      (x),
        .cnt    (cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: conversion phase (0 none, 1 waiting converter start,
    // 2 converting), who was served last, delivered data and completed count.
    int         m_conv;
    bit         m_last;
    bit         m_g;
    logic [7:0] m_d [2];
    logic [7:0] m_cnt;
    bit         pa0;
    bit         pa1;
    int         nconv;
    int         ngrant [2];

    // Converter agent state.
    int         cph;
    int         cdly;

    task automatic reset_model();
        m_conv = 0;
        m_last = 1'b1;
        m_d[0] = 8'd0;
        m_d[1] = 8'd0;
        m_cnt  = 8'd0;
        pa0    = 1'b0;
        pa1    = 1'b0;
        cph    = 0;
        cdly   = 0;
        eoc    = 1'b1;
    endtask

    // One clock: remember what the DUT samples, move to the negedge, check, drive.
    task automatic step();
        bit         s0;
        bit         s1;
        bit         se;
        logic [7:0] sx;
        bit         ea0;
        bit         ea1;
        bit         es;
        s0 = req0;
        s1 = req1;
        se = eoc;
        sx = x;
        @(negedge clock);

        // An ack already up stays up exactly as long as its request is held.
        ea0 = pa0 && s0;
        ea1 = pa1 && s1;
        es  = 1'b0;
        if (m_conv == 0) begin
            if (!pa0 && !pa1 && (s0 || s1)) begin
                m_g    = (s0 && s1) ? !m_last : s1;
                m_conv = 1;
                es     = 1'b1;
                ngrant[m_g]++;
            end
        end else if (m_conv == 1) begin
            if (se) es = 1'b1;
            else    m_conv = 2;
        end else begin
            if (se) begin
                m_d[m_g] = sx;
                m_cnt    = m_cnt + 8'd1;
                m_last   = m_g;
                if (m_g) ea1 = 1'b1;
                else     ea0 = 1'b1;
                m_conv   = 0;
                nconv++;
            end
        end

        check("soc",  soc,  es);
        check("ack0", ack0, ea0);
        check("ack1", ack1, ea1);
        check("d0",   d0,   m_d[0]);
        check("d1",   d1,   m_d[1]);
        check("cnt",  cnt,  m_cnt);
        pa0 = ea0;
        pa1 = ea1;

        // Converter: after soc, start (eoc low) after 0..3 cycles, finish 1..5 later.
        case (cph)
            0: if (soc) begin
                   cdly = $urandom_range(0, 3);
                   cph  = 1;
               end
            default: ;
        endcase
        if (cph == 1) begin
            if (cdly == 0) begin
                eoc  = 1'b0;
                cdly = $urandom_range(1, 5);
                cph  = 2;
            end else begin
                cdly--;
            end
        end else if (cph == 2) begin
            cdly--;
            if (cdly == 0) begin
                eoc = 1'b1;
                x   = 8'($urandom);
                cph = 0;
            end
        end

        // Requesters: 4-phase with occasional early withdrawal.
        if (!req0 && !ack0)      begin if ($urandom_range(0, 2) == 0)  req0 = 1'b1; end
        else if (req0 && ack0)   begin if ($urandom_range(0, 1) == 0)  req0 = 1'b0; end
        else if (req0 && !ack0)  begin if ($urandom_range(0, 23) == 0) req0 = 1'b0; end
        if (!req1 && !ack1)      begin if ($urandom_range(0, 2) == 0)  req1 = 1'b1; end
        else if (req1 && ack1)   begin if ($urandom_range(0, 1) == 0)  req1 = 1'b0; end
        else if (req1 && !ack1)  begin if ($urandom_range(0, 23) == 0) req1 = 1'b0; end
    endtask

    initial begin
        bit seen;
        nconv     = 0;
        ngrant[0] = 0;
        ngrant[1] = 0;
        m_g       = 1'b0;
        reset_    = 1'b0;
        req0      = 1'b0;
        req1      = 1'b0;
        x         = 8'd0;
        reset_model();
        repeat (3) @(negedge clock);
        check("rst_soc",  soc,  1'b0);
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_d0",   d0,   8'd0);
        check("rst_d1",   d1,   8'd0);
        check("rst_cnt",  cnt,  8'd0);

        // Tie straight out of reset: requester 0 must be served first.
        reset_ = 1'b1;
        req0   = 1'b1;
        req1   = 1'b1;
        for (int i = 0; i < 6000; i++) step();
        check("wrap_cov", (nconv >= 256), 1'b1);
        check("both_served", (ngrant[0] > 0 && ngrant[1] > 0), 1'b1);

        // Asynchronous reset in the middle of a conversion request.
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            if (soc) seen = 1'b1;
        end
        check("soc_seen", seen, 1'b1);
        #2 reset_ = 1'b0;
        #1;
        check("arst_soc",  soc,  1'b0);
        check("arst_ack0", ack0, 1'b0);
        check("arst_ack1", ack1, 1'b0);
        check("arst_d0",   d0,   8'd0);
        check("arst_d1",   d1,   8'd0);
        check("arst_cnt",  cnt,  8'd0);
        repeat (2) @(negedge clock);
        reset_model();
        reset_ = 1'b1;
        nconv  = 0;
        for (int i = 0; i < 600; i++) step();
        check("restart_conv", (nconv > 0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
